// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared definitions for the sidetone generator: FSM state encoding and the
// default preset half-periods. The defaults assume a 1 MHz system clock.
// No ports (package only).
// ---------------------------------------------------------------------------
package tone_pkg;

   // Controller states. IDLE must stay at zero so a cleared register is idle.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN_CONT = 2'd1,
      RUN_BEEP = 2'd2,
      DRAIN    = 2'd3
   } tone_state_t;

   // Clock assumption behind the default presets.
   localparam int unsigned F_CLK_HZ    = 1_000_000;
   localparam int unsigned SIDETONE_HZ = 600;

   // Half-period of the classic 600 Hz sidetone, in clocks (833 at 1 MHz).
   localparam int unsigned HALF_600HZ  = F_CLK_HZ / (2 * SIDETONE_HZ);

   // Default preset half-periods: 600, 800, 500 and 400 Hz at 1 MHz.
   localparam int unsigned DEF_HALF0 = HALF_600HZ;
   localparam int unsigned DEF_HALF1 = 625;
   localparam int unsigned DEF_HALF2 = 1000;
   localparam int unsigned DEF_HALF3 = 1250;

endpackage

// File: rtl/tone_divider.sv
// ---------------------------------------------------------------------------
// tone_divider
// Half-period counter plus toggle flip-flop producing the square wave.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   run          high while the controller is (or is about to be) running
//   half         latched half-period in clocks (>= 2)
//   tone_out     registered square-wave output
//   fall_strobe  high during the last cycle of a high phase
//   rise_strobe  high during the last cycle of a low phase
// ---------------------------------------------------------------------------
module tone_divider
   import tone_pkg::*;
#(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [CNT_W-1:0] half,
   output logic             tone_out,
   output logic             fall_strobe,
   output logic             rise_strobe
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt;
   logic             active;
   logic             at_end;

   // The strobes look one cycle ahead: they flag the cycle whose closing edge
   // ends the current phase, so the controller can decide on that same edge.
   assign at_end      = active && (cnt == (half - ONE));
   assign fall_strobe = at_end && tone_out;
   assign rise_strobe = at_end && !tone_out;

   // Counter and toggle. Dropping 'run' clears everything on the next edge,
   // which is how the controller forces the output low when a tone ends.
   // The first running edge starts a fresh high phase with the counter at 0.
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         active   <= 1'b0;
         cnt      <= '0;
         tone_out <= 1'b0;
      end else if (!active) begin
         active   <= 1'b1;
         cnt      <= '0;
         tone_out <= 1'b1;
      end else if (at_end) begin
         cnt      <= '0;
         tone_out <= !tone_out;
      end else begin
         cnt      <= cnt + ONE;
      end
   end

endmodule

// File: rtl/tone_synth.sv
// ---------------------------------------------------------------------------
// tone_synth
// Square-wave sidetone generator with four preset pitches. Plays either a
// continuous tone while 'en' is high or a one-shot beep of N full periods.
// A high phase is never cut short when a tone stops.
// Ports:
//   clk          system clock (1 MHz nominal)
//   rst          synchronous active-high reset
//   en           level request for a continuous tone
//   pitch_sel    preset select, sampled only when a tone starts
//   beep         one-cycle start pulse for a one-shot beep
//   beep_cycles  number of full periods in the beep (0 plays one period)
//   tone_out     registered square-wave output
//   busy         registered, high whenever the controller is not idle
// ---------------------------------------------------------------------------
module tone_synth
   import tone_pkg::*;
#(
   parameter int CNT_W  = 12,
   parameter int HALF0  = DEF_HALF0,
   parameter int HALF1  = DEF_HALF1,
   parameter int HALF2  = DEF_HALF2,
   parameter int HALF3  = DEF_HALF3,
   parameter int BEEP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        pitch_sel,
   input  logic              beep,
   input  logic [BEEP_W-1:0] beep_cycles,
   output logic              tone_out,
   output logic              busy
);

   localparam logic [BEEP_W-1:0] BEEP_ONE = BEEP_W'(1);

   tone_state_t       state;
   tone_state_t       state_next;
   logic [CNT_W-1:0]  preset;
   logic [CNT_W-1:0]  half_q;
   logic [BEEP_W-1:0] remain;
   logic              load_tone;
   logic              load_beep;
   logic              dec_remain;
   logic              run;
   logic              fall_strobe;
   logic              rise_strobe;

   // Preset mux. Only consulted on the edge that starts a tone, so later
   // changes to pitch_sel cannot disturb a tone already playing.
   always_comb begin
      preset = CNT_W'(HALF0);
      case (pitch_sel)
         2'd0:    preset = CNT_W'(HALF0);
         2'd1:    preset = CNT_W'(HALF1);
         2'd2:    preset = CNT_W'(HALF2);
         2'd3:    preset = CNT_W'(HALF3);
         default: preset = CNT_W'(HALF0);
      endcase
   end

   // Next-state logic. beep wins over en in IDLE; requests arriving while
   // busy are simply not looked at. A continuous tone stopping in a high
   // phase drains to the end of that phase; stopping in a low phase (or on
   // the very last high cycle) returns to IDLE straight away. A beep counts
   // whole periods, so it is decremented at the end of each low phase.
   always_comb begin
      state_next = state;
      load_tone  = 1'b0;
      load_beep  = 1'b0;
      dec_remain = 1'b0;
      case (state)
         IDLE: begin
            if (beep) begin
               state_next = RUN_BEEP;
               load_tone  = 1'b1;
               load_beep  = 1'b1;
            end else if (en) begin
               state_next = RUN_CONT;
               load_tone  = 1'b1;
            end
         end
         RUN_CONT: begin
            if (!en) begin
               if (tone_out && !fall_strobe) begin
                  state_next = DRAIN;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         RUN_BEEP: begin
            if (rise_strobe) begin
               dec_remain = 1'b1;
               if (remain <= BEEP_ONE) begin
                  state_next = IDLE;
               end
            end
         end
         DRAIN: begin
            if (fall_strobe) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The divider runs whenever the controller will be out of IDLE after this
   // edge, so tone_out rises on the same edge the FSM leaves IDLE and drops
   // on the same edge it returns.
   assign run = (state_next != IDLE);

   // State register, latched pitch, beep period counter and busy flag.
   // busy is registered from state_next so it tracks the state exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         half_q <= '0;
         remain <= '0;
         busy   <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
         if (load_tone) begin
            half_q <= preset;
         end
         if (load_beep) begin
            remain <= (beep_cycles == '0) ? BEEP_ONE : beep_cycles;
         end else if (dec_remain) begin
            remain <= remain - BEEP_ONE;
         end
      end
   end

   tone_divider #(
      .CNT_W (CNT_W)
   ) u_divider (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .half        (half_q),
      .tone_out    (tone_out),
      .fall_strobe (fall_strobe),
      .rise_strobe (rise_strobe)
   );

endmodule

// File: tb/tb_tone_synth.sv
// ---------------------------------------------------------------------------
// tb_tone_synth
// Directed self-checking bench for tone_synth with small presets
// (HALF0=4, HALF1=3, HALF2=5, HALF3=6). Each step drives one cycle of inputs,
// queues the {tone_out, busy} pair expected after the next rising edge, and
// compares it once that edge has passed.
// ---------------------------------------------------------------------------
module tb_tone_synth;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] pitch_sel;
   logic       beep;
   logic [7:0] beep_cycles;
   logic       tone_out;
   logic       busy;

   logic [1:0] exp_q[$];
   string      tag_q[$];
   int         check_cnt;
   int         pass_cnt;

   tone_synth #(
      .CNT_W  (12),
      .HALF0  (4),
      .HALF1  (3),
      .HALF2  (5),
      .HALF3  (6),
      .BEEP_W (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .pitch_sel   (pitch_sel),
      .beep        (beep),
      .beep_cycles (beep_cycles),
      .tone_out    (tone_out),
      .busy        (busy)
   );

   // 10 time-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish (observed timeout, required finish)");
      $fatal(1, "[TB] watchdog expired");
   end

   // Pops the oldest expectation and compares it with the DUT outputs.
   task automatic checkOutput();
      logic [1:0] expected;
      logic [1:0] observed;
      string      tag;
      expected = exp_q.pop_front();
      tag      = tag_q.pop_front();
      observed = {tone_out, busy};
      check_cnt++;
      assert (observed === expected) pass_cnt++;
      else $error("[TB] FAIL %s: {tone_out,busy} observed %b expected %b", tag, observed, expected);
   endtask

   // Drives one cycle of inputs at the falling edge, queues the expected
   // outputs for the following rising edge, then checks them 1 unit later.
   task automatic applyStimulus(input logic r, input logic e, input logic b,
                                input logic [7:0] bc, input logic [1:0] ps,
                                input logic exp_tone, input logic exp_busy,
                                input string tag);
      @(negedge clk);
      rst         = r;
      en          = e;
      beep        = b;
      beep_cycles = bc;
      pitch_sel   = ps;
      exp_q.push_back({exp_tone, exp_busy});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   // Square-wave reference: high for the first 'half' cycles of each period.
   function automatic logic waveHigh(input int idx, input int half);
      return ((idx / half) % 2) == 0;
   endfunction

   initial begin
      check_cnt   = 0;
      pass_cnt    = 0;
      rst         = 1'b1;
      en          = 1'b0;
      beep        = 1'b0;
      beep_cycles = 8'd0;
      pitch_sel   = 2'd0;

      // Reset state
      applyStimulus(1, 0, 0, 8'd0, 2'd0, 0, 0, "reset0");
      applyStimulus(1, 0, 0, 8'd0, 2'd0, 0, 0, "reset1");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 0, 0, "idle_after_reset");

      // Continuous tone at HALF0=4, then stop during a low phase
      for (int i = 0; i < 22; i++)
         applyStimulus(0, 1, 0, 8'd0, 2'd0, waveHigh(i, 4), 1, $sformatf("cont%0d", i));
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 0, 0, "cont_stop_low");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 0, 0, "idle1");

      // Drain: en drops in the 2nd high cycle, returns during DRAIN (ignored)
      applyStimulus(0, 1, 0, 8'd0, 2'd0, 1, 1, "drain_start");
      applyStimulus(0, 1, 0, 8'd0, 2'd0, 1, 1, "drain_hi1");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 1, 1, "drain_hold2");
      applyStimulus(0, 1, 0, 8'd0, 2'd0, 1, 1, "drain_hold3");
      applyStimulus(0, 1, 0, 8'd0, 2'd0, 0, 0, "drain_end");
      // en still high in the single IDLE cycle -> new tone
      applyStimulus(0, 1, 0, 8'd0, 2'd0, 1, 1, "rearm_start");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 1, 1, "rearm_hold1");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 1, 1, "rearm_hold2");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 1, 1, "rearm_hold3");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 0, 0, "rearm_end");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 0, 0, "idle2");

      // Beep: 3 periods at HALF1=3; second beep and en mid-beep are ignored
      for (int j = 0; j < 18; j++) begin
         logic       b;
         logic       e;
         logic [7:0] bc;
         logic [1:0] ps;
         b  = (j == 0) || (j == 7);
         e  = (j >= 5) && (j <= 10);
         bc = (j == 0) ? 8'd3 : ((j == 7) ? 8'd9 : 8'd0);
         ps = (j == 0) ? 2'd1 : ((j == 7) ? 2'd3 : 2'd2);
         applyStimulus(0, e, b, bc, ps, waveHigh(j, 3), 1, $sformatf("beep%0d", j));
      end
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 0, 0, "beep_end");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 0, 0, "idle3");

      // beep and en together with beep_cycles=0 -> one 8-cycle period
      applyStimulus(0, 1, 1, 8'd0, 2'd0, 1, 1, "prio0");
      for (int k = 1; k < 8; k++)
         applyStimulus(0, 1, 0, 8'd0, 2'd0, waveHigh(k, 4), 1, $sformatf("prio%0d", k));
      applyStimulus(0, 1, 0, 8'd0, 2'd0, 0, 0, "prio_end");

      // Continuous tone follows; pitch_sel 0->3 mid-tone keeps 8-cycle period
      for (int m = 0; m < 16; m++)
         applyStimulus(0, 1, 0, 8'd0, (m >= 2) ? 2'd3 : 2'd0, waveHigh(m, 4), 1,
                       $sformatf("latch%0d", m));
      applyStimulus(0, 0, 0, 8'd0, 2'd3, 0, 0, "latch_stop");

      // Next tone picks up HALF3=6 -> 12-cycle period
      for (int n = 0; n < 12; n++)
         applyStimulus(0, 1, 0, 8'd0, 2'd3, waveHigh(n, 6), 1, $sformatf("pitch3_%0d", n));
      applyStimulus(0, 0, 0, 8'd0, 2'd3, 0, 0, "pitch3_stop");

      // Reset during the high phase of a beep at HALF2=5
      applyStimulus(0, 0, 1, 8'd2, 2'd2, 1, 1, "rbeep0");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 1, 1, "rbeep1");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 1, 1, "rbeep2");
      applyStimulus(1, 0, 0, 8'd0, 2'd0, 0, 0, "rbeep_reset");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 0, 0, "rbeep_idle");

      // Beep after reset starts normally: one period at HALF0=4
      applyStimulus(0, 0, 1, 8'd1, 2'd0, 1, 1, "post0");
      for (int q = 1; q < 8; q++)
         applyStimulus(0, 0, 0, 8'd0, 2'd0, waveHigh(q, 4), 1, $sformatf("post%0d", q));
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 0, 0, "post_end");
      applyStimulus(0, 0, 0, 8'd0, 2'd0, 0, 0, "idle_final");

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
